// File: rtl/seg7_sequencer_if.sv
// Control and display bundle between the pin-level controller and seg7_sequencer.
interface seg7_sequencer_if;
  logic       ena;
  logic [2:0] speed;
  logic       pause;
  logic       auto_en;
  logic       btn_next;
  logic       anim_load;
  logic [3:0] anim_sel;
  logic [3:0] counter;
  logic [3:0] animation;
  logic       blank;
  logic       frame_tick;

  modport master (
    output ena, speed, pause, auto_en, btn_next, anim_load, anim_sel,
    input  counter, animation, blank, frame_tick
  );

  modport slave (
    input  ena, speed, pause, auto_en, btn_next, anim_load, anim_sel,
    output counter, animation, blank, frame_tick
  );
endinterface

// File: rtl/seg7_sequencer.sv
// Frame sequencer for the 7-segment animation decoder: prescaler, button debounce, RUN/HOLD/BLANK FSM.
// Define SEQ_AUTO_CYCLE_EN to build the unattended auto-advance through animations.
module seg7_sequencer #(
  parameter int DIV_WIDTH       = 24,
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter int LOOPS           = 3
) (
  input logic             clk,
  input logic             rst,
  seg7_sequencer_if.slave bus
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] BLANK = 2'd2;

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [DBW-1:0] DB_HIT = DBW'(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] DB_SAT = DBW'(DEBOUNCE_CYCLES + 1);

  logic [1:0]           state_q, state_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [3:0]           counter_q, counter_d;
  logic [3:0]           anim_q, anim_d;
  logic [3:0]           pend_q, pend_d;
  logic                 frame_tick_q, frame_tick_d;
  logic                 sync1_q, sync2_q;
  logic [DBW-1:0]       db_q, db_d;
  logic                 press_q, press_d;

`ifdef SEQ_AUTO_CYCLE_EN
  localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  logic [LW-1:0] loop_q, loop_d;
`else
  logic unused_auto;
  assign unused_auto = bus.auto_en;
`endif

  logic [DIV_WIDTH-1:0] period_m1;
  logic                 count_en, tick, load_ok;
  logic [3:0]           anim_inc;

  function automatic logic [3:0] frame_last(input logic [3:0] a);
    case (a)
      4'd0:                         return 4'd9;
      4'd1:                         return 4'd11;
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6: return 4'd5;
      4'd8, 4'd9:                   return 4'd3;
      default:                      return 4'd1;
    endcase
  endfunction

  // All-ones shifted right by speed gives 2^(DIV_WIDTH-speed)-1.
  assign period_m1 = {DIV_WIDTH{1'b1}} >> bus.speed;
  assign count_en  = (state_q == BLANK) || ((state_q == RUN) && !bus.pause);
  assign tick      = count_en && (presc_q >= period_m1);
  assign load_ok   = bus.anim_load && (bus.anim_sel <= 4'd11);
  assign anim_inc  = (anim_q == 4'd11) ? 4'd0 : anim_q + 4'd1;

  // Saturating one past the threshold makes the press fire once per high level.
  assign db_d    = !sync2_q ? '0 : ((db_q == DB_SAT) ? db_q : db_q + 1'b1);
  assign press_d = sync2_q && (db_q == DB_HIT);

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    counter_d    = counter_q;
    anim_d       = anim_q;
    pend_d       = pend_q;
    frame_tick_d = 1'b0;
`ifdef SEQ_AUTO_CYCLE_EN
    loop_d       = loop_q;
`endif
    if (load_ok) begin
      state_d = BLANK;
      pend_d  = bus.anim_sel;
      presc_d = '0;
    end else if (press_q) begin
      state_d = BLANK;
      pend_d  = anim_inc;
      presc_d = '0;
    end else begin
      if (count_en) presc_d = tick ? '0 : presc_q + 1'b1;
      case (state_q)
        RUN: begin
          if (bus.pause) begin
            state_d = HOLD;
          end else if (tick) begin
            frame_tick_d = 1'b1;
            if (counter_q == frame_last(anim_q)) begin
              counter_d = 4'd0;
`ifdef SEQ_AUTO_CYCLE_EN
              if (loop_q == LW'(LOOPS - 1)) begin
                loop_d = '0;
                if (bus.auto_en) begin
                  state_d = BLANK;
                  pend_d  = anim_inc;
                end
              end else begin
                loop_d = loop_q + 1'b1;
              end
`endif
            end else begin
              counter_d = counter_q + 4'd1;
            end
          end
        end
        HOLD: if (!bus.pause) state_d = RUN;
        BLANK: begin
          if (tick) begin
            anim_d       = pend_q;
            counter_d    = 4'd0;
            frame_tick_d = 1'b1;
            state_d      = RUN;
`ifdef SEQ_AUTO_CYCLE_EN
            loop_d       = '0;
`endif
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      presc_q      <= '0;
      counter_q    <= 4'd0;
      anim_q       <= 4'd0;
      pend_q       <= 4'd0;
      frame_tick_q <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_q         <= '0;
      press_q      <= 1'b0;
`ifdef SEQ_AUTO_CYCLE_EN
      loop_q       <= '0;
`endif
    end else if (bus.ena) begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      counter_q    <= counter_d;
      anim_q       <= anim_d;
      pend_q       <= pend_d;
      frame_tick_q <= frame_tick_d;
      sync1_q      <= bus.btn_next;
      sync2_q      <= sync1_q;
      db_q         <= db_d;
      press_q      <= press_d;
`ifdef SEQ_AUTO_CYCLE_EN
      loop_q       <= loop_d;
`endif
    end
  end

  assign bus.counter    = counter_q;
  assign bus.animation  = anim_q;
  assign bus.blank      = (state_q == BLANK);
  assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg7_sequencer.sv
// Directed bench for seg7_sequencer with DIV_WIDTH=8, DEBOUNCE_CYCLES=4, LOOPS=2.
module tb_seg7_sequencer;
`ifdef SEQ_AUTO_CYCLE_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cur_anim;

  seg7_sequencer_if bus();

  seg7_sequencer #(
    .DIV_WIDTH      (8),
    .DEBOUNCE_CYCLES(4),
    .LOOPS          (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int cnt, input int anim,
                            input int blk, input int ft);
    check({tag, "_counter"}, bus.counter, cnt);
    check({tag, "_animation"}, bus.animation, anim);
    check({tag, "_blank"}, bus.blank, blk);
    check({tag, "_frame_tick"}, bus.frame_tick, ft);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ena       = 1'b1;
    bus.speed     = 3'd7;
    bus.pause     = 1'b0;
    bus.auto_en   = 1'b0;
    bus.btn_next  = 1'b0;
    bus.anim_load = 1'b0;
    bus.anim_sel  = 4'd0;
    step(3);
    expect_out("reset", 0, 0, 0, 0);

    // Basic counting at P=2: animation 0 has 10 frames.
    rst = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      step(1);
      check("basic_counter", bus.counter, (k / 2) % 10);
      check("basic_tick", bus.frame_tick, (k % 2 == 0) ? 1 : 0);
      check("basic_blank", bus.blank, 0);
    end
    check("basic_animation", bus.animation, 0);

    // Load animation 7 (2 frames) with auto-advance after two passes.
    bus.anim_load = 1'b1;
    bus.anim_sel  = 4'd7;
    bus.auto_en   = 1'b1;
    step(1);
    bus.anim_load = 1'b0;
    expect_out("load_a0", 1, 0, 1, 0);
    step(1);
    expect_out("load_a1", 1, 0, 1, 0);
    step(1);
    expect_out("load_a2", 0, 7, 0, 1);
    for (int j = 1; j <= 8; j++) begin
      step(1);
      check("auto_counter", bus.counter, (j / 2) % 2);
      check("auto_tick", bus.frame_tick, (j % 2 == 0) ? 1 : 0);
      check("auto_blank", bus.blank, (j == 8) ? AUTO : 0);
    end
    step(1);
    expect_out("auto_a11", 0, 7, AUTO, 0);
    step(1);
    expect_out("auto_a12", (AUTO == 1) ? 0 : 1, (AUTO == 1) ? 8 : 7, 0, 1);
    bus.auto_en = 1'b0;
    cur_anim = (AUTO == 1) ? 8 : 7;

    // Short glitch on the button is filtered out.
    bus.btn_next = 1'b1;
    step(3);
    bus.btn_next = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check("db_short_blank", bus.blank, 0);
    end
    check("db_short_anim", bus.animation, cur_anim);

    // Long press: blank rises 7 edges after the first high sample.
    bus.btn_next = 1'b1;
    step(7);
    check("db_long_c7_blank", bus.blank, 0);
    step(1);
    check("db_long_c8_blank", bus.blank, 1);
    step(2);
    check("db_long_anim", bus.animation, cur_anim + 1);
    check("db_long_c10_blank", bus.blank, 0);
    bus.btn_next = 1'b0;
    step(20);
    check("db_single_anim", bus.animation, cur_anim + 1);
    check("db_single_blank", bus.blank, 0);

    // Animation 11 wraps to 0 on a press.
    bus.anim_load = 1'b1;
    bus.anim_sel  = 4'd11;
    step(1);
    bus.anim_load = 1'b0;
    check("wrap_load_blank", bus.blank, 1);
    step(2);
    check("wrap_load_anim", bus.animation, 11);
    bus.btn_next = 1'b1;
    step(10);
    bus.btn_next = 1'b0;
    check("wrap_press_anim", bus.animation, 0);
    step(6);
    check("wrap_after_anim", bus.animation, 0);
    check("wrap_after_blank", bus.blank, 0);

    // Out-of-range load is ignored.
    bus.anim_load = 1'b1;
    bus.anim_sel  = 4'd12;
    step(1);
    bus.anim_load = 1'b0;
    check("range_blank", bus.blank, 0);
    check("range_anim", bus.animation, 0);
    step(3);
    check("range_later_blank", bus.blank, 0);
    check("range_later_anim", bus.animation, 0);

    // Pause at prescaler count 5 with P=16.
    bus.speed     = 3'd4;
    bus.anim_load = 1'b1;
    bus.anim_sel  = 4'd2;
    step(1);
    bus.anim_load = 1'b0;
    check("pause_d0_blank", bus.blank, 1);
    step(15);
    check("pause_d15_blank", bus.blank, 1);
    step(1);
    expect_out("pause_d16", 0, 2, 0, 1);
    step(5);
    bus.pause = 1'b1;
    step(20);
    expect_out("pause_held", 0, 2, 0, 0);
    bus.pause = 1'b0;
    step(1);
    check("pause_release_counter", bus.counter, 0);
    step(10);
    expect_out("pause_r10", 0, 2, 0, 0);
    step(1);
    expect_out("pause_r11", 1, 2, 0, 1);

    // Reset in the middle of BLANK discards the pending animation.
    bus.anim_load = 1'b1;
    bus.anim_sel  = 4'd5;
    step(1);
    bus.anim_load = 1'b0;
    step(3);
    check("rstblank_blank", bus.blank, 1);
    rst = 1'b1;
    step(1);
    expect_out("rstblank", 0, 0, 0, 0);
    rst = 1'b0;
    step(40);
    check("rstblank_after_anim", bus.animation, 0);
    check("rstblank_after_blank", bus.blank, 0);
    check("rstblank_after_counter", bus.counter, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
